sd_cmd: RTL and testbench
=========================

SD_CMD -- requirements
Module: sd_cmd

Interface
REQ-001 Parameter NCR_MAX, default 64: maximum number of iclk cycles from the command end bit to the response start bit before a timeout.
REQ-002 Parameter NCC, default 8: idle cycles after the end bit of a command that has no response.
REQ-003 Port irst, input, 1: asynchronous reset, active-high.
REQ-004 Port iclk, input, 1: single clock; one CMD-line bit per cycle.
REQ-005 Port istart, input, 1: one-cycle request to issue a command.
REQ-006 Port iindex, input, 6: command index, sampled on istart.
REQ-007 Port iarg, input, 32: command argument, sampled on istart.
REQ-008 Port icmd, input, 1: CMD line as seen by the receiver, sampled on the iclk rising edge.
REQ-009 Port ocmd, output, 1: CMD line drive value.
REQ-010 Port ocmd_oe, output, 1: CMD line drive enable; 0 means released (pulled up).
REQ-011 Port ocmd_done, output, 1: one-cycle pulse marking command completion.
REQ-012 Port oresp, output, 76: received response payload.
REQ-013 Port ocrc_err, output, 1: response CRC7 mismatch.
REQ-014 Port otimeout, output, 1: no response start bit seen within NCR_MAX cycles.

Function
REQ-015 The block SHALL implement the states IDLE -> SEND -> (WAIT_RESP -> RECV | GAP) -> DONE -> IDLE.
REQ-016 istart in IDLE SHALL latch iindex/iarg, clear ocrc_err/otimeout/oresp, and enter SEND; istart in any other state SHALL be ignored.
REQ-017 SEND SHALL drive 48 bits MSB-first with ocmd_oe=1, one bit per cycle, starting the cycle after istart; frame = 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1.
REQ-018 CRC7 SHALL use the polynomial x^7+x^3+1 with an initial value of 0, computed over the first 40 frame bits.
REQ-019 ocmd_oe SHALL drop to 0 and ocmd SHALL return to 1 in the cycle after the end bit.
REQ-020 Response type SHALL be selected from the latched index:
- 15: none
- 2, 9: R2, 136 bits
- 41: R3, 48 bits, no CRC check
- all others: R1/R1b, 48 bits
REQ-021 For a none-type command, the block SHALL wait NCC cycles in GAP and then go to DONE.
REQ-022 WAIT_RESP SHALL count cycles from the one after the end bit; icmd=0 SHALL be the start bit and move the block to RECV.
REQ-023 If the count reaches NCR_MAX without a start bit, the block SHALL set otimeout=1, keep oresp=0, and go to DONE.
REQ-024 RECV SHALL shift in the remaining 47 (R1/R3) or 135 (R2) bits.
REQ-025 oresp SHALL hold the received bits excluding the final 8 (CRC7 + end bit), right-aligned: oresp[i] = frame bit i+8.
- R1/R3: oresp[31:0] = card status/OCR; oresp[75:40] = 0.
- R2: oresp[75:0] = CID/CSD[83:8].
REQ-026 For R1, CRC7 SHALL be checked over the first 40 received bits; for R2, over frame bits 127:8 (the 120 bits after the 8-bit header).
REQ-027 A CRC mismatch SHALL set ocrc_err=1; oresp SHALL still be updated.
REQ-028 R1b busy (DAT0) is not handled here; R1b SHALL be treated as R1.
REQ-029 DONE SHALL assert ocmd_done for exactly one cycle, then return to IDLE.
REQ-030 oresp, ocrc_err and otimeout SHALL be valid in the ocmd_done cycle and held until the next accepted istart.
REQ-031 Latency SHALL be:
- none type: ocmd_done exactly 1+48+NCC+1 cycles after istart;
- response types: ocmd_done the cycle after the last response bit is sampled.
REQ-032 istart coinciding with the ocmd_done cycle SHALL be ignored; it SHALL be accepted from IDLE only.
REQ-033 icmd SHALL be ignored in SEND, GAP, IDLE and DONE.

Reset
REQ-034 irst SHALL force, asynchronously: state=IDLE, ocmd=1, ocmd_oe=0, ocmd_done=0, oresp=0, ocrc_err=0, otimeout=0, all counters 0.
REQ-035 irst asserted mid-operation SHALL abort without an ocmd_done pulse; the first istart after release SHALL be served normally.

Verification
REQ-036 istart, index 8, arg 0x000001AA -> ocmd bits 0x48_00_00_01_AA_87 on 48 consecutive cycles starting 1 cycle after istart, with ocmd_oe=1 throughout.
REQ-037 istart, index 55, arg 0 -> frame 0x77_00_00_00_00_65; card replies with a valid R1, status 0x00000120, after 5 cycles -> ocmd_done pulse, oresp[31:0]=0x00000120, ocrc_err=0.
REQ-038 index 41; card replies 0x3F_80FF8000_FF (bad CRC field) -> oresp[31:0]=0x80FF8000, ocrc_err=0.
REQ-039 index 9; card sends R2 with CSD READ_BL_LEN=9, C_SIZE=0xFFF, C_SIZE_MULT=7 -> oresp[75:72]=9, oresp[65:54]=0xFFF, oresp[41:39]=7; a corrupted CRC bit -> ocrc_err=1.
REQ-040 index 3 with icmd held at 1 -> otimeout=1, oresp=0, ocmd_done exactly NCR_MAX cycles after the end bit.
REQ-041 index 15 -> ocmd_done 58 cycles after istart; istart during SEND ignored; irst during RECV -> ocmd_oe=0 and no ocmd_done.

Source files
------------

// File: rtl/sd_cmd.sv
// SD card CMD-line engine: serialises a 48-bit command with CRC7, then either idles
// for NCC cycles or captures and CRC-checks the R1/R2/R3 response with a start-bit timeout.
module sd_cmd #(
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [5:0]  iindex,
  input  logic [31:0] iarg,
  input  logic        icmd,
  output logic        ocmd,
  output logic        ocmd_oe,
  output logic        ocmd_done,
  output logic [75:0] oresp,
  output logic        ocrc_err,
  output logic        otimeout
);

  localparam int CNT_TOP = (NCR_MAX > NCC) ? ((NCR_MAX > 47) ? NCR_MAX : 47)
                                           : ((NCC > 47) ? NCC : 47);
  localparam int CW = $clog2(CNT_TOP + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECV, GAP, DONE} state_t;
  typedef enum logic [1:0] {RT_NONE, RT_R1, RT_R2, RT_R3} rtype_t;

  state_t         state_reg;
  rtype_t         rtype_reg;
  rtype_t         cmd_rtype;
  logic [46:0]    tx_sr_reg;
  logic [CW-1:0]  cnt_reg;
  logic [7:0]     rx_cnt_reg;
  logic [82:0]    rx_sr_reg;
  logic [6:0]     crc_reg;
  logic [47:0]    tx_frame;
  logic [7:0]     rx_last;
  logic [7:0]     crc_lo;
  logic [7:0]     crc_hi;
  logic           rx_in_crc;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] crc;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) crc = crc7_step(crc, d[i]);
    return crc;
  endfunction

  always_comb begin
    tx_frame = {2'b01, iindex, iarg, crc7_40({2'b01, iindex, iarg}), 1'b1};
    case (iindex)
      6'd15:        cmd_rtype = RT_NONE;
      6'd2, 6'd9:   cmd_rtype = RT_R2;
      6'd41:        cmd_rtype = RT_R3;
      default:      cmd_rtype = RT_R1;
    endcase
  end

  // rx_cnt counts frame bits from the start bit; the start bit itself never changes a zero CRC
  always_comb begin
    rx_last   = (rtype_reg == RT_R2) ? 8'd135 : 8'd47;
    crc_lo    = (rtype_reg == RT_R2) ? 8'd8   : 8'd1;
    crc_hi    = (rtype_reg == RT_R2) ? 8'd127 : 8'd39;
    rx_in_crc = (rx_cnt_reg >= crc_lo) && (rx_cnt_reg <= crc_hi);
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_reg  <= IDLE;
      rtype_reg  <= RT_NONE;
      tx_sr_reg  <= '0;
      cnt_reg    <= '0;
      rx_cnt_reg <= '0;
      rx_sr_reg  <= '0;
      crc_reg    <= '0;
      ocmd       <= 1'b1;
      ocmd_oe    <= 1'b0;
      ocmd_done  <= 1'b0;
      oresp      <= '0;
      ocrc_err   <= 1'b0;
      otimeout   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (istart) begin
            tx_sr_reg <= tx_frame[46:0];
            ocmd      <= tx_frame[47];
            ocmd_oe   <= 1'b1;
            rtype_reg <= cmd_rtype;
            cnt_reg   <= '0;
            oresp     <= '0;
            ocrc_err  <= 1'b0;
            otimeout  <= 1'b0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (cnt_reg == CW'(47)) begin
            ocmd      <= 1'b1;
            ocmd_oe   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= (rtype_reg == RT_NONE) ? GAP : WAIT_RESP;
          end else begin
            ocmd      <= tx_sr_reg[46];
            tx_sr_reg <= {tx_sr_reg[45:0], 1'b0};
            cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        // GAP spans the NCC idle cycles plus the release cycle after the end bit
        GAP: begin
          if (cnt_reg == CW'(NCC)) begin
            cnt_reg   <= '0;
            ocmd_done <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_RESP: begin
          if (!icmd) begin
            rx_cnt_reg <= 8'd1;
            rx_sr_reg  <= '0;
            crc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= RECV;
          end else if (cnt_reg == CW'(NCR_MAX - 2)) begin
            cnt_reg   <= '0;
            otimeout  <= 1'b1;
            ocmd_done <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RECV: begin
          rx_sr_reg  <= {rx_sr_reg[81:0], icmd};
          rx_cnt_reg <= rx_cnt_reg + 1'b1;
          if (rx_in_crc) crc_reg <= crc7_step(crc_reg, icmd);
          // icmd is the end bit here; rx_sr holds frame bits 83..1
          if (rx_cnt_reg == rx_last) begin
            rx_cnt_reg <= '0;
            oresp      <= rx_sr_reg[82:7];
            ocrc_err   <= (rtype_reg != RT_R3) && (crc_reg != rx_sr_reg[6:0]);
            ocmd_done  <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          ocmd_done <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd.sv
// Bench for sd_cmd: directed vector table, random commands against a frame-level model,
// and hand-written reset-abort / ignored-istart sequences.
module tb_sd_cmd;
  localparam int NCR   = 64;
  localparam int NCC_P = 8;

  logic        iclk = 1'b0;
  logic        irst, istart, icmd;
  logic [5:0]  iindex;
  logic [31:0] iarg;
  logic        ocmd, ocmd_oe, ocmd_done, ocrc_err, otimeout;
  logic [75:0] oresp;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 iclk = ~iclk;

  sd_cmd #(.NCR_MAX(NCR), .NCC(NCC_P)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iindex(iindex), .iarg(iarg), .icmd(icmd),
    .ocmd(ocmd), .ocmd_oe(ocmd_oe), .ocmd_done(ocmd_done), .oresp(oresp),
    .ocrc_err(ocrc_err), .otimeout(otimeout)
  );

  // mode: 0 card silent, 1 good reply, 2 reply with a flipped CRC bit, 3 raw 48-bit frame in body
  typedef struct packed {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   mode;
    int           delay;
    logic [127:0] body;
    logic         chk_tx;
    logic [47:0]  exp_tx;
    logic [75:0]  exp_resp;
    logic [75:0]  resp_mask;
    logic         exp_crc;
    logic         exp_to;
    int           exp_lat;
    int           inj_send;
    logic         inj_done;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string what, input logic [135:0] act, input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_div(input logic [127:0] msg, input int n);
    logic [134:0] r;
    r = 135'(msg) << 7;
    for (int i = n + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic int rlen(input logic [5:0] idx);
    if (idx == 6'd15) return 0;
    if (idx == 6'd2 || idx == 6'd9) return 136;
    return 48;
  endfunction

  function automatic logic [135:0] card_frame(input vec_t v);
    logic [135:0] rf;
    if (v.mode == 2'd3)
      rf = 136'(v.body[47:0]);
    else if (rlen(v.idx) == 136)
      rf = {8'h3F, v.body[119:0], crc7_div(128'(v.body[119:0]), 120), 1'b1};
    else if (v.idx == 6'd41)
      rf = 136'({2'b00, 6'h3F, v.body[31:0], 7'h7F, 1'b1});
    else
      rf = 136'({2'b00, v.idx, v.body[31:0],
                 crc7_div(128'({2'b00, v.idx, v.body[31:0]}), 40), 1'b1});
    if (v.mode == 2'd2) rf[1] = ~rf[1];
    return rf;
  endfunction

  function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [1:0] mode, input int delay, input logic [127:0] body);
    vec_t v;
    v = '0;
    v.idx = idx; v.arg = arg; v.mode = mode; v.delay = delay; v.body = body;
    v.resp_mask = '1;
    return v;
  endfunction

  function automatic vec_t model(input vec_t vin);
    vec_t v;
    logic [135:0] rf;
    int L;
    v = vin;
    v.chk_tx = 1'b1;
    v.exp_tx = {2'b01, v.idx, v.arg, crc7_div(128'({2'b01, v.idx, v.arg}), 40), 1'b1};
    v.resp_mask = '1; v.exp_resp = '0; v.exp_crc = 1'b0; v.exp_to = 1'b0;
    L = rlen(v.idx);
    if (L == 0) begin
      v.exp_lat = 1 + 48 + NCC_P + 1;
    end else if (v.mode == 2'd0 || v.delay > NCR - 2) begin
      v.exp_to  = 1'b1;
      v.exp_lat = 48 + NCR;
    end else begin
      rf = card_frame(v);
      v.exp_resp = rf[83:8];
      v.exp_crc  = (v.mode == 2'd2) && (v.idx != 6'd41);
      v.exp_lat  = 1 + 48 + v.delay + L;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [135:0] rf;
    logic [47:0]  tx;
    logic [75:0]  hold;
    int           L, done_c, st;
    bit           oe_ok, rel_ok, quiet;
    rf = card_frame(v);
    L = rlen(v.idx);
    st = 49 + v.delay;
    done_c = -1; oe_ok = 1; rel_ok = 1; tx = '0;
    @(negedge iclk);
    istart = 1'b1; iindex = v.idx; iarg = v.arg; icmd = 1'b1;
    for (int c = 1; c <= 400 && done_c < 0; c++) begin
      @(negedge iclk);
      istart = 1'b0; iindex = 6'($urandom); iarg = $urandom;
      if (c == 1) check($sformatf("v%0d cleared", id), {oresp, ocrc_err, otimeout}, 78'b0);
      if (c <= 48) begin
        tx[48 - c] = ocmd;
        if (ocmd_oe !== 1'b1) oe_ok = 0;
      end else if (ocmd_oe !== 1'b0 || ocmd !== 1'b1) begin
        rel_ok = 0;
      end
      if (ocmd_done === 1'b1) begin
        done_c = c;
      end else begin
        if (v.inj_send == c) begin istart = 1'b1; iindex = 6'd15; end
        if (c <= 48) icmd = 1'($urandom);
        else if (L > 0 && v.mode != 2'd0 && c >= st && c < st + L) icmd = rf[L - 1 - (c - st)];
        else icmd = 1'b1;
      end
    end
    if (v.chk_tx) check($sformatf("v%0d tx_frame", id), tx, v.exp_tx);
    check($sformatf("v%0d oe_in_send", id), oe_ok, 1'b1);
    check($sformatf("v%0d released", id), rel_ok, 1'b1);
    check($sformatf("v%0d done_latency", id), done_c, v.exp_lat);
    check($sformatf("v%0d oresp", id), oresp & v.resp_mask, v.exp_resp & v.resp_mask);
    check($sformatf("v%0d crc_err", id), ocrc_err, v.exp_crc);
    check($sformatf("v%0d timeout", id), otimeout, v.exp_to);
    $display("[TB] v%0d idx=%0d arg=%h done@%0d resp=%h crc=%b to=%b",
             id, v.idx, v.arg, done_c, oresp, ocrc_err, otimeout);
    hold = oresp; quiet = 1;
    if (v.inj_done) begin istart = 1'b1; iindex = 6'd15; end
    icmd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge iclk);
      istart = 1'b0;
      if (ocmd_done !== 1'b0 || ocmd_oe !== 1'b0 || oresp !== hold) quiet = 0;
    end
    check($sformatf("v%0d post_done_quiet", id), quiet, 1'b1);
  endtask

  initial begin
    vec_t v;
    logic [127:0] csd;
    logic [135:0] rf;
    bit saw_done, saw_oe;

    irst = 1'b1; istart = 1'b0; icmd = 1'b1; iindex = '0; iarg = '0;
    repeat (3) @(negedge iclk);
    check("reset_state", {ocmd, ocmd_oe, ocmd_done, oresp, ocrc_err, otimeout},
          {1'b1, 1'b0, 1'b0, 76'b0, 1'b0, 1'b0});
    irst = 1'b0;

    csd = '0; csd[83:80] = 4'd9; csd[73:62] = 12'hFFF; csd[49:47] = 3'd7;

    tbl[0] = mk(6'd8, 32'h1AA, 2'd1, 3, 128'h1AA);
    tbl[0].chk_tx = 1; tbl[0].exp_tx = 48'h48000001AA87;
    tbl[0].exp_resp = 76'h1AA; tbl[0].resp_mask = 76'hFFFFFFFF; tbl[0].exp_lat = 100;
    tbl[1] = mk(6'd55, 32'h0, 2'd1, 5, 128'h120);
    tbl[1].chk_tx = 1; tbl[1].exp_tx = 48'h770000000065;
    tbl[1].exp_resp = 76'h120; tbl[1].resp_mask = 76'hFFFFFFFF; tbl[1].exp_lat = 102;
    tbl[1].inj_done = 1;
    tbl[2] = mk(6'd41, 32'h40FF8000, 2'd3, 2, 128'h3F80FF8000FF);
    tbl[2].exp_resp = 76'h3F80FF8000; tbl[2].exp_lat = 99;
    tbl[3] = mk(6'd9, 32'h0, 2'd1, 4, 128'(csd[127:8]));
    tbl[3].exp_resp = (76'd9 << 72) | (76'hFFF << 54) | (76'd7 << 39);
    tbl[3].resp_mask = (76'hF << 72) | (76'hFFF << 54) | (76'h7 << 39); tbl[3].exp_lat = 189;
    tbl[4] = tbl[3]; tbl[4].mode = 2'd2; tbl[4].delay = 0; tbl[4].exp_crc = 1; tbl[4].exp_lat = 185;
    tbl[5] = mk(6'd3, 32'h0, 2'd0, 0, 128'h0);
    tbl[5].exp_to = 1; tbl[5].exp_lat = 48 + NCR;
    tbl[6] = mk(6'd15, 32'h0, 2'd0, 0, 128'h0);
    tbl[6].exp_lat = 58; tbl[6].inj_send = 10;
    tbl[7] = mk(6'd17, 32'h1234, 2'd1, NCR - 2, 128'h900);
    tbl[7].exp_resp = 76'h900; tbl[7].resp_mask = 76'hFFFFFFFF; tbl[7].exp_lat = 159;
    tbl[8] = mk(6'd17, 32'h1234, 2'd1, NCR - 1, 128'h900);
    tbl[8].exp_to = 1; tbl[8].exp_lat = 48 + NCR;
    tbl[9] = mk(6'd2, 32'h0, 2'd1, 1, {8'h0, 44'hFFF00000ABC, 76'h123456789ABCDEF0123});
    tbl[9].exp_resp = 76'h123456789ABCDEF0123; tbl[9].exp_lat = 186;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Reset in the middle of a response: immediate release, no completion afterwards
    v = mk(6'd17, 32'hCAFE0001, 2'd1, 2, 128'h55);
    rf = card_frame(v);
    saw_done = 0; saw_oe = 0;
    @(negedge iclk);
    istart = 1'b1; iindex = v.idx; iarg = v.arg;
    for (int c = 1; c <= 220; c++) begin
      @(negedge iclk);
      istart = 1'b0;
      if (c == 71) begin
        irst = 1'b1;
        #1;
        check("rst_async_outputs", {ocmd_oe, ocmd, ocmd_done, oresp, ocrc_err, otimeout},
              {1'b0, 1'b1, 1'b0, 76'b0, 1'b0, 1'b0});
      end
      if (c == 72) irst = 1'b0;
      if (c > 71) begin
        if (ocmd_done === 1'b1) saw_done = 1;
        if (ocmd_oe === 1'b1) saw_oe = 1;
      end
      icmd = (c >= 51 && c < 99) ? rf[47 - (c - 51)] : 1'b1;
    end
    check("rst_no_done", saw_done, 1'b0);
    check("rst_no_drive", saw_oe, 1'b0);
    $display("[TB] reset during RECV: done_seen=%b oe_seen=%b", saw_done, saw_oe);
    run_vec(tbl[0], 100);

    for (int i = 0; i < 40; i++) begin
      int sel, r;
      logic [5:0] pick[8];
      pick = '{6'd0, 6'd2, 6'd9, 6'd15, 6'd41, 6'd17, 6'd55, 6'd3};
      sel = $urandom_range(0, 8);
      v = mk((sel == 8) ? 6'($urandom) : pick[sel], $urandom, 2'd1,
             $urandom_range(0, NCR - 1), {$urandom, $urandom, $urandom, $urandom});
      r = $urandom_range(0, 9);
      v.mode = (r == 0) ? 2'd0 : (r <= 2) ? 2'd2 : 2'd1;
      run_vec(model(v), 200 + i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
